// File: rtl/sort_feeder_pkg.sv
// sort_pkg: shared FSM state types and default geometry for the sort feeder.
package sort_pkg;
  localparam int AWIDTH_DEF = 8;
  localparam int DWIDTH_DEF = 8;
  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_SEND, R_FREE} rstate_e;
endpackage

// File: rtl/sort_feeder_bank_ram.sv
// sort_feeder_bank_ram: simple dual-port RAM, bank index is the address MSB, registered read.
module sort_feeder_bank_ram #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [AWIDTH:0]   waddr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AWIDTH:0]   raddr_i,
  output logic [DWIDTH-1:0] rdata_o
);
  logic [DWIDTH-1:0] mem [2**(AWIDTH+1)];
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end
  // Only the read register is cleared; the array itself keeps its contents.
  always_ff @(posedge clk_i) begin
    if (rst_i) rdata_o <= '0;
    else if (re_i) rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/sort_feeder.sv
// sort_feeder: ping-pong packet buffer that hands only complete packets to the sorter.
module sort_feeder
  import sort_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              sop_i,
  input  logic              eop_i,
  input  logic              val_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              sop_o,
  output logic              eop_o,
  output logic              val_o,
  input  logic              busy_i,
  output logic              drop_o,
  output logic              full_o
);
  wstate_e ws_q, ws_d;
  rstate_e rs_q, rs_d;
  logic wb_q, wb_d, rb_q, rb_d;
  logic [AWIDTH:0] wa_q, wa_d, ram_wa;
  logic [AWIDTH-1:0] ra_q, ra_d;
  logic [1:0] vld_q, vld_d, set_v, clr_v;
  logic [1:0][AWIDTH:0] len_q, len_d;
  logic drop_q, drop_d, sop_q, sop_d, eop_q, eop_d, val_q, val_d, full_q;
  logic we, re, last;
  assign last = {1'b0, ra_q} == len_q[rb_q] - 1'b1;
  assign vld_d = (vld_q | set_v) & ~clr_v;
  always_comb begin
    ws_d = ws_q;
    wb_d = wb_q;
    wa_d = wa_q;
    len_d = len_q;
    set_v = '0;
    drop_d = 1'b0;
    we = 1'b0;
    ram_wa = {wb_q, wa_q[AWIDTH-1:0]};
    if (val_i && sop_i) begin
      // A sop inside W_FILL restarts the current (already owned) bank.
      if (ws_q == W_FILL || !vld_q[wb_q]) begin
        we = 1'b1;
        ram_wa = {wb_q, {AWIDTH{1'b0}}};
        wa_d = {{AWIDTH{1'b0}}, 1'b1};
        drop_d = ws_q == W_FILL;
        ws_d = eop_i ? W_IDLE : W_FILL;
        if (eop_i) begin
          set_v[wb_q] = 1'b1;
          len_d[wb_q] = {{AWIDTH{1'b0}}, 1'b1};
          wb_d = ~wb_q;
        end
      end else begin
        drop_d = 1'b1;
        ws_d = eop_i ? W_IDLE : W_DROP;
      end
    end else if (val_i && ws_q == W_FILL) begin
      if (wa_q[AWIDTH]) begin
        drop_d = 1'b1;
        ws_d = eop_i ? W_IDLE : W_DROP;
      end else begin
        we = 1'b1;
        wa_d = wa_q + 1'b1;
        if (eop_i) begin
          set_v[wb_q] = 1'b1;
          len_d[wb_q] = wa_q + 1'b1;
          wb_d = ~wb_q;
          ws_d = W_IDLE;
        end
      end
    end else if (val_i && eop_i && ws_q == W_DROP) begin
      ws_d = W_IDLE;
    end
  end
  always_comb begin
    rs_d = rs_q;
    rb_d = rb_q;
    ra_d = ra_q;
    clr_v = '0;
    re = 1'b0;
    val_d = 1'b0;
    sop_d = 1'b0;
    eop_d = 1'b0;
    if (rs_q == R_IDLE && vld_q[rb_q] && !busy_i) begin
      rs_d = R_SEND;
      ra_d = '0;
    end else if (rs_q == R_SEND) begin
      re = 1'b1;
      val_d = 1'b1;
      sop_d = ra_q == '0;
      eop_d = last;
      ra_d = ra_q + 1'b1;
      rs_d = last ? R_FREE : R_SEND;
    end else if (rs_q == R_FREE) begin
      clr_v[rb_q] = 1'b1;
      rb_d = ~rb_q;
      rs_d = R_IDLE;
    end
  end
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      ws_q <= W_IDLE;
      rs_q <= R_IDLE;
      wb_q <= 1'b0;
      rb_q <= 1'b0;
      wa_q <= '0;
      ra_q <= '0;
      vld_q <= '0;
      len_q <= '0;
      drop_q <= 1'b0;
      sop_q <= 1'b0;
      eop_q <= 1'b0;
      val_q <= 1'b0;
      full_q <= 1'b0;
    end else begin
      ws_q <= ws_d;
      rs_q <= rs_d;
      wb_q <= wb_d;
      rb_q <= rb_d;
      wa_q <= wa_d;
      ra_q <= ra_d;
      vld_q <= vld_d;
      len_q <= len_d;
      drop_q <= drop_d;
      sop_q <= sop_d;
      eop_q <= eop_d;
      val_q <= val_d;
      full_q <= &vld_d;
    end
  end
  sort_feeder_bank_ram #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) u_ram (
    .clk_i   (clk_i),
    .rst_i   (srst_i),
    .we_i    (we),
    .waddr_i (ram_wa),
    .wdata_i (data_i),
    .re_i    (re),
    .raddr_i ({rb_q, ra_q}),
    .rdata_o (data_o)
  );
  assign sop_o = sop_q;
  assign eop_o = eop_q;
  assign val_o = val_q;
  assign drop_o = drop_q;
  assign full_o = full_q;
endmodule
